// File: rtl/complex_integrate_dump.sv
// complex_integrate_dump
//   Streaming complex integrate-and-dump. Sums a programmable number of
//   consecutive {imag, real} samples at full precision and emits one sum per
//   integration period. s_last closes a period early.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   length          samples per period minus one (latched at period start)
//   s_valid/s_ready input handshake; s_data = {imag, real}, s_last ends period
//   m_valid/m_ready output handshake; m_data = {imag sum, real sum}
//   m_count         number of samples summed into m_data
module complex_integrate_dump #(
    parameter int WIDTH        = 16,
    parameter int LENGTH_WIDTH = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [LENGTH_WIDTH-1:0]           length,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [2*WIDTH-1:0]                s_data,
    input  logic                              s_last,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [2*(WIDTH+LENGTH_WIDTH)-1:0] m_data,
    output logic [LENGTH_WIDTH:0]             m_count
);

    localparam int OWIDTH = WIDTH + LENGTH_WIDTH;

    logic signed [OWIDTH-1:0]   acc_re_q, acc_re_d;
    logic signed [OWIDTH-1:0]   acc_im_q, acc_im_d;
    logic [LENGTH_WIDTH:0]      count_q, count_d;
    logic [LENGTH_WIDTH-1:0]    len_q, len_d;
    logic                       m_valid_q, m_valid_d;
    logic [2*OWIDTH-1:0]        m_data_q, m_data_d;
    logic [LENGTH_WIDTH:0]      m_count_q, m_count_d;

    logic                       accept;
    logic                       first;
    logic                       dump;
    logic [LENGTH_WIDTH-1:0]    eff_len;
    logic signed [OWIDTH-1:0]   smp_re, smp_im;
    logic signed [OWIDTH-1:0]   sum_re, sum_im;
    logic [LENGTH_WIDTH:0]      count_inc;

    // Ready depends only on the output register, never on s_valid.
    assign s_ready = !m_valid_q || m_ready;
    assign accept  = s_valid && s_ready;
    assign first   = (count_q == '0);

    // On the first beat the live length applies; afterwards the latched one.
    assign eff_len   = first ? length : len_q;
    assign count_inc = count_q + (LENGTH_WIDTH+1)'(1);
    assign dump      = accept && ((count_q == {1'b0, eff_len}) || s_last);

    assign smp_re = {{LENGTH_WIDTH{s_data[WIDTH-1]}},   s_data[WIDTH-1:0]};
    assign smp_im = {{LENGTH_WIDTH{s_data[2*WIDTH-1]}}, s_data[2*WIDTH-1:WIDTH]};
    assign sum_re = first ? smp_re : acc_re_q + smp_re;
    assign sum_im = first ? smp_im : acc_im_q + smp_im;

    always_comb begin
        acc_re_d  = acc_re_q;
        acc_im_d  = acc_im_q;
        count_d   = count_q;
        len_d     = len_q;
        m_valid_d = m_valid_q && !m_ready;
        m_data_d  = m_data_q;
        m_count_d = m_count_q;
        if (accept) begin
            acc_re_d = sum_re;
            acc_im_d = sum_im;
            if (first) begin
                len_d = length;
            end
            if (dump) begin
                count_d   = '0;
                m_valid_d = 1'b1;
                m_data_d  = {sum_im, sum_re};
                m_count_d = count_inc;
            end else begin
                count_d = count_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_re_q  <= '0;
            acc_im_q  <= '0;
            count_q   <= '0;
            len_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_count_q <= '0;
        end else begin
            acc_re_q  <= acc_re_d;
            acc_im_q  <= acc_im_d;
            count_q   <= count_d;
            len_q     <= len_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_count_q <= m_count_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_count = m_count_q;

endmodule

// File: tb/tb_complex_integrate_dump.sv
module tb_complex_integrate_dump;

  localparam int W  = 16;
  localparam int LW = 8;
  localparam int OW = W + LW;

  logic              clk = 1'b0;
  logic              reset;
  logic [LW-1:0]     length;
  logic              s_valid;
  logic              s_ready;
  logic [2*W-1:0]    s_data;
  logic              s_last;
  logic              m_valid;
  logic              m_ready;
  logic [2*OW-1:0]   m_data;
  logic [LW:0]       m_count;

  complex_integrate_dump #(.WIDTH(W), .LENGTH_WIDTH(LW)) dut (
    .clk(clk), .reset(reset), .length(length),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_count(m_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
  endtask

  function automatic logic [2*OW-1:0] pack(input longint re, input longint im);
    logic [OW-1:0] r, i;
    r = re[OW-1:0];
    i = im[OW-1:0];
    return {i, r};
  endfunction

  // ---------------- reference model ----------------
  // Keeps the samples of the open period in queues; a dump sums them.
  longint        per_re[$];
  longint        per_im[$];
  int            mlen;
  bit            ev;
  logic [2*OW-1:0] ed;
  int            ec;

  always @(negedge clk) begin
    bit nev, acc;
    int eff;
    longint sr, si;
    chk("m_valid", 64'(m_valid), 64'(ev));
    chk("s_ready", 64'(s_ready), 64'(!ev || m_ready));
    if (ev) begin
      chk("m_data", 64'(m_data), 64'(ed));
      chk("m_count", 64'(m_count), 64'(ec));
    end
    if (reset) begin
      per_re.delete(); per_im.delete();
      mlen = 0; ev = 0; ed = '0; ec = 0;
    end else begin
      acc = s_valid && (!ev || m_ready);
      nev = ev && !m_ready;
      if (acc) begin
        if (per_re.size() == 0) mlen = int'(length);
        eff = mlen;
        per_re.push_back(longint'($signed(s_data[W-1:0])));
        per_im.push_back(longint'($signed(s_data[2*W-1:W])));
        if (per_re.size() == eff + 1 || s_last) begin
          sr = 0; si = 0;
          foreach (per_re[k]) begin sr += per_re[k]; si += per_im[k]; end
          ed = pack(sr, si);
          ec = per_re.size();
          nev = 1;
          per_re.delete(); per_im.delete();
        end
      end
      ev = nev;
    end
  end

  // ---------------- drivers ----------------
  task automatic send(input int re, input int im, input bit last);
    logic [W-1:0] r, i;
    bit ok;
    r = re[W-1:0];
    i = im[W-1:0];
    s_data  = {i, r};
    s_valid = 1'b1;
    s_last  = last;
    ok = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (s_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      $display("FAIL send_timeout actual=stalled expected=accepted");
      checks++;
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  typedef struct {
    int len; int re; int im; bit last;
    longint exp_re; longint exp_im; int exp_cnt;
  } vec_t;

  vec_t tbl[6];

  logic [2*OW-1:0] held;

  initial begin
    tbl[0] = '{0,      5,     -3, 0,      5,     -3, 1};
    tbl[1] = '{0, -32768,  32767, 0, -32768,  32767, 1};
    tbl[2] = '{7,    100,   -100, 1,    100,   -100, 1};
    tbl[3] = '{255,    -1,    -1, 1,     -1,     -1, 1};
    tbl[4] = '{0,  32767, -32768, 0,  32767, -32768, 1};
    tbl[5] = '{3,      0,      0, 1,      0,      0, 1};

    reset = 1; length = '0; s_valid = 0; s_data = '0; s_last = 0; m_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data",  64'(m_data),  64'd0);
    chk("rst_m_count", 64'(m_count), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    reset = 0;

    // basic sum
    length = 3;
    for (int k = 1; k <= 4; k++) begin
      if (k < 4) begin
        send(k, -k, 0);
        chk("basic_no_early_valid", 64'(m_valid), 64'd0);
      end else send(k, -k, 0);
    end
    chk("basic_valid", 64'(m_valid), 64'd1);
    chk("basic_data",  64'(m_data), 64'(48'hFFFFF6_00000A));
    chk("basic_count", 64'(m_count), 64'd4);

    // full-scale negative
    length = 255;
    for (int k = 0; k < 256; k++) send(-32768, -32768, 0);
    chk("full_data",  64'(m_data), 64'(48'h800000_800000));
    chk("full_count", 64'(m_count), 64'd256);

    // early termination, then a full 8-beat period
    length = 7;
    send(5, 5, 0); send(5, 5, 0); send(5, 5, 1);
    chk("early_data",  64'(m_data), 64'(pack(15, 15)));
    chk("early_count", 64'(m_count), 64'd3);
    for (int k = 0; k < 8; k++) send(1, 2, 0);
    chk("after_early_data",  64'(m_data), 64'(pack(8, 16)));
    chk("after_early_count", 64'(m_count), 64'd8);

    // single-beat table (pass-through and s_last on first beat)
    foreach (tbl[v]) begin
      length = tbl[v].len[LW-1:0];
      send(tbl[v].re, tbl[v].im, tbl[v].last);
      chk($sformatf("tbl%0d_valid", v), 64'(m_valid), 64'd1);
      chk($sformatf("tbl%0d_data", v),  64'(m_data), 64'(pack(tbl[v].exp_re, tbl[v].exp_im)));
      chk($sformatf("tbl%0d_count", v), 64'(m_count), 64'(tbl[v].exp_cnt));
    end

    // backpressure
    length = 1;
    send(10, 20, 0);
    send(30, 40, 0);
    m_ready = 0;
    held = pack(40, 60);
    s_data = {16'd70, 16'd50}; s_valid = 1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_s_ready", 64'(s_ready), 64'd0);
      chk("bp_data",    64'(m_data), 64'(held));
      chk("bp_count",   64'(m_count), 64'd2);
    end
    @(posedge clk); #1;
    m_ready = 1;
    send(50, 70, 0);
    send(60, 80, 0);
    chk("bp_resume_data",  64'(m_data), 64'(pack(110, 150)));
    chk("bp_resume_count", 64'(m_count), 64'd2);

    // length change mid-period
    length = 3;
    send(1, 1, 0); send(1, 1, 0);
    length = 1;
    send(1, 1, 0); send(1, 1, 0);
    chk("lenchg_count4", 64'(m_count), 64'd4);
    send(2, 2, 0); send(2, 2, 0);
    chk("lenchg_count2", 64'(m_count), 64'd2);
    chk("lenchg_data",   64'(m_data), 64'(pack(4, 4)));

    // reset mid-period
    length = 3;
    send(100, 100, 0); send(100, 100, 0);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("midrst_valid", 64'(m_valid), 64'd0);
    for (int k = 0; k < 4; k++) send(1, -1, 0);
    chk("midrst_data",  64'(m_data), 64'(pack(4, -4)));
    chk("midrst_count", 64'(m_count), 64'd4);

    // randomized traffic, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = $urandom;
      if ($urandom_range(0, 3) == 0) s_data[W-1:0] = 16'h8000;
      s_last  = ($urandom_range(0, 9) == 0);
      m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) length = LW'($urandom_range(0, 9));
    end
    @(posedge clk); #1;
    s_valid = 0; s_last = 0; m_ready = 1;
    repeat (3) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
